// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_if
// Purpose  : Bundles the commit-stage, CSR-file and timer signals of the trap
//            sequencer.
//            slave  - seen from trap_ctrl (commit/CSR inputs in, writes out)
//            master - seen from the pipeline/CSR side driving trap_ctrl
// Ports    : commit_valid/pc/ecall/mret, mtie, mstatus_in, mtvec_in, mepc_in,
//            mtimecmp_we/wdata            -> into the sequencer
//            mepc/mcause/mstatus write ports, stall, redirect/redirect_addr,
//            mtip, mtime, mtimecmp       -> out of the sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        commit_ecall;
    logic        commit_mret;
    logic        mtie;
    logic [63:0] mstatus_in;
    logic [63:0] mtvec_in;
    logic [63:0] mepc_in;
    logic        mtimecmp_we;
    logic [63:0] mtimecmp_wdata;

    logic        mepc_we;
    logic [63:0] mepc_wdata;
    logic        mcause_we;
    logic [63:0] mcause_wdata;
    logic        mstatus_we;
    logic [63:0] mstatus_wdata;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_addr;
    logic        mtip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    modport slave (
        input  commit_valid, commit_pc, commit_ecall, commit_mret, mtie,
               mstatus_in, mtvec_in, mepc_in, mtimecmp_we, mtimecmp_wdata,
        output mepc_we, mepc_wdata, mcause_we, mcause_wdata, mstatus_we,
               mstatus_wdata, stall, redirect, redirect_addr, mtip, mtime,
               mtimecmp
    );

    modport master (
        output commit_valid, commit_pc, commit_ecall, commit_mret, mtie,
               mstatus_in, mtvec_in, mepc_in, mtimecmp_we, mtimecmp_wdata,
        input  mepc_we, mepc_wdata, mcause_we, mcause_wdata, mstatus_we,
               mstatus_wdata, stall, redirect, redirect_addr, mtip, mtime,
               mtimecmp
    );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Multi-cycle machine-mode trap sequencer. Owns every hardware
//            write to mepc/mcause/mstatus, takes ecall, mret and the machine
//            timer interrupt from commit, holds mtime/mtimecmp, stalls the
//            pipeline while busy and ends each sequence with one redirect.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - trap_ctrl_if.slave (commit, CSR, timer and redirect signals)
// Params   : TICK_DIV     - clk cycles per mtime increment (1..65535)
//            MTIMECMP_RST - reset value of mtimecmp
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    trap_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_T_SAVE = 3'd1;
    localparam logic [2:0] S_T_STAT = 3'd2;
    localparam logic [2:0] S_T_JMP  = 3'd3;
    localparam logic [2:0] S_R_STAT = 3'd4;
    localparam logic [2:0] S_R_JMP  = 3'd5;

    localparam logic [63:0] c_CAUSE_MTI   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] c_CAUSE_ECALL = 64'h0000_0000_0000_000B;
    localparam logic [15:0] c_TICK_MAX    = 16'(TICK_DIV - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_tick;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [63:0] r_mepc_d;
    logic [63:0] r_mcause_d;
    logic [63:0] r_mstatus_hold;
    logic [63:0] r_target;

    logic        w_mtip;
    logic        w_irq;
    logic        w_take;
    logic        w_take_trap;
    logic        w_take_ret;
    logic [63:0] w_mstatus_trap;
    logic [63:0] w_mstatus_ret;

    logic        w_mepc_we;
    logic        w_mcause_we;
    logic        w_mstatus_we;
    logic        w_stall;
    logic        w_redirect;
    logic [63:0] w_mstatus_wdata;

    logic        w_unused;

    // ------------------------------------------------------------------
    // Timer: prescaler wraps at TICK_DIV-1 and bumps mtime on the wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick  <= 16'd0;
            r_mtime <= 64'd0;
        end else if (r_tick == c_TICK_MAX) begin
            r_tick  <= 16'd0;
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_tick  <= r_tick + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtimecmp <= MTIMECMP_RST;
        end else if (bus.mtimecmp_we) begin
            r_mtimecmp <= bus.mtimecmp_wdata;
        end
    end

    assign w_mtip = (r_mtime >= r_mtimecmp);

    // ------------------------------------------------------------------
    // Acceptance: interrupt beats ecall beats mret; only from IDLE.
    // ------------------------------------------------------------------
    assign w_irq       = w_mtip & bus.mtie & bus.mstatus_in[3];
    assign w_take      = (r_state == S_IDLE) & bus.commit_valid;
    assign w_take_trap = w_take & (w_irq | bus.commit_ecall);
    assign w_take_ret  = w_take & ~w_irq & ~bus.commit_ecall & bus.commit_mret;

    // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and mret
    // (MIE<=MPIE, MPIE<=1); MPP is always machine mode.
    always_comb begin
        w_mstatus_trap        = bus.mstatus_in;
        w_mstatus_trap[7]     = bus.mstatus_in[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;

        w_mstatus_ret         = bus.mstatus_in;
        w_mstatus_ret[3]      = bus.mstatus_in[7];
        w_mstatus_ret[7]      = 1'b1;
        w_mstatus_ret[12:11]  = 2'b11;
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_trap) begin
                    w_next = S_T_SAVE;
                end else if (w_take_ret) begin
                    w_next = S_R_STAT;
                end
            end
            S_T_SAVE: w_next = S_T_STAT;
            S_T_STAT: w_next = S_T_JMP;
            S_T_JMP:  w_next = S_IDLE;
            S_R_STAT: w_next = S_R_JMP;
            S_R_JMP:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mepc_we       = 1'b0;
        w_mcause_we     = 1'b0;
        w_mstatus_we    = 1'b0;
        w_redirect      = 1'b0;
        w_stall         = (r_state != S_IDLE);
        w_mstatus_wdata = r_mstatus_hold;
        case (r_state)
            S_T_SAVE: begin
                w_mepc_we   = 1'b1;
                w_mcause_we = 1'b1;
            end
            S_T_STAT: begin
                w_mstatus_we    = 1'b1;
                w_mstatus_wdata = w_mstatus_trap;
            end
            S_R_STAT: begin
                w_mstatus_we    = 1'b1;
                w_mstatus_wdata = w_mstatus_ret;
            end
            S_T_JMP, S_R_JMP: begin
                w_redirect = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Data latches. Each one only changes on entry to the cycle whose
    // strobe it accompanies, so the value holds while the strobe is low.
    // mstatus is taken live from mstatus_in during the STAT cycle and
    // copied into the hold register at its end.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mepc_d       <= 64'd0;
            r_mcause_d     <= 64'd0;
            r_mstatus_hold <= 64'd0;
            r_target       <= 64'd0;
        end else begin
            if (w_take_trap) begin
                r_mepc_d   <= bus.commit_pc;
                r_mcause_d <= w_irq ? c_CAUSE_MTI : c_CAUSE_ECALL;
            end
            if (r_state == S_T_STAT) begin
                r_mstatus_hold <= w_mstatus_trap;
                r_target       <= {bus.mtvec_in[63:2], 2'b00};
            end
            if (r_state == S_R_STAT) begin
                r_mstatus_hold <= w_mstatus_ret;
                r_target       <= bus.mepc_in;
            end
        end
    end

    assign bus.mepc_we       = w_mepc_we;
    assign bus.mepc_wdata    = r_mepc_d;
    assign bus.mcause_we     = w_mcause_we;
    assign bus.mcause_wdata  = r_mcause_d;
    assign bus.mstatus_we    = w_mstatus_we;
    assign bus.mstatus_wdata = w_mstatus_wdata;
    assign bus.stall         = w_stall;
    assign bus.redirect      = w_redirect;
    assign bus.redirect_addr = r_target;
    assign bus.mtip          = w_mtip;
    assign bus.mtime         = r_mtime;
    assign bus.mtimecmp      = r_mtimecmp;

    // mtvec mode bits are dropped when forming the vector base.
    assign w_unused = &{1'b0, bus.mtvec_in[1:0]};

endmodule
`default_nettype wire
